// File: rtl/exec_unit_md.sv
// exec_unit_md: registered execute stage with a single-cycle ALU, a
// valid/ready handshake and an iterative multiply/divide unit that owns the
// architectural HI/LO registers.
module exec_unit_md #(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       aluctrl,
  input  logic             i_type,
  input  logic [WIDTH-1:0] d1_in,
  input  logic [WIDTH-1:0] d2_in,
  input  logic [WIDTH-1:0] imm_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] d1_out,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_ADDU  = 5'b00011;
  localparam logic [4:0] OP_SUBU  = 5'b00100;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_PASS  = 5'b00111;
  localparam logic [4:0] OP_NOR   = 5'b01100;
  localparam logic [4:0] OP_SLL   = 5'b01101;
  localparam logic [4:0] OP_SRL   = 5'b01110;
  localparam logic [4:0] OP_SRA   = 5'b01111;
  localparam logic [4:0] OP_SLT   = 5'b10000;
  localparam logic [4:0] OP_SLTU  = 5'b10001;
  localparam logic [4:0] OP_BEQ   = 5'b10010;
  localparam logic [4:0] OP_BGTZ  = 5'b10011;
  localparam logic [4:0] OP_BGEZ  = 5'b10100;
  localparam logic [4:0] OP_LUI   = 5'b10101;
  localparam logic [4:0] OP_BNE   = 5'b10110;
  localparam logic [4:0] OP_MULT  = 5'b11000;
  localparam logic [4:0] OP_MULTU = 5'b11001;
  localparam logic [4:0] OP_DIV   = 5'b11010;
  localparam logic [4:0] OP_DIVU  = 5'b11011;
  localparam logic [4:0] OP_MFHI  = 5'b11100;
  localparam logic [4:0] OP_MFLO  = 5'b11101;
  localparam logic [4:0] OP_MTHI  = 5'b11110;
  localparam logic [4:0] OP_MTLO  = 5'b11111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 divOp_q, divOp_d;
  logic                 negRes_q, negRes_d;
  logic                 negRem_q, negRem_d;
  logic                 divZero_q, divZero_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 zero_q, zero_d, ovf_q, ovf_d, ovalid_q, ovalid_d;

  logic [WIDTH-1:0]     opB, sum, diff, resD;
  logic                 zeroD, ovfD;
  logic [SW-1:0]        shamt;
  logic                 accept, isMul, isDiv, signedOp, negA, negB;
  logic [WIDTH-1:0]     magA, magB;
  logic [WIDTH:0]       mulSum, remTmp;
  logic                 remFits;
  logic [WIDTH-1:0]     remNew;
  logic [2*WIDTH-1:0]   prodFix;
  logic [WIDTH-1:0]     quoFix, remFix, fixHi, fixLo;

  assign opB      = i_type ? imm_in : d2_in;
  assign sum      = d1_in + opB;
  assign diff     = d1_in - opB;
  assign shamt    = imm_in[SW-1:0];
  assign accept   = in_valid && in_ready;
  assign isMul    = (aluctrl == OP_MULT) || (aluctrl == OP_MULTU);
  assign isDiv    = DIV_EN && ((aluctrl == OP_DIV) || (aluctrl == OP_DIVU));
  assign signedOp = (aluctrl == OP_MULT) || (aluctrl == OP_DIV);
  assign negA     = signedOp && d1_in[WIDTH-1];
  assign negB     = signedOp && d2_in[WIDTH-1];
  assign magA     = negA ? -d1_in : d1_in;
  assign magB     = negB ? -d2_in : d2_in;

  // One shift-add step: conditionally add the multiplicand into the top half.
  assign mulSum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? a_q : {WIDTH{1'b0}})};
  // One restoring-divide step: shift in the next dividend bit, try to subtract.
  assign remTmp  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign remFits = remTmp >= {1'b0, a_q};
  assign remNew  = remTmp[WIDTH-1:0] - a_q;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ovalid_q;
  assign d1_out    = dout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

  // Single-cycle ALU result, condition flag and signed overflow.
  always_comb begin
    resD  = '0;
    zeroD = 1'b0;
    ovfD  = 1'b0;
    case (aluctrl)
      OP_ADD: begin
        resD = sum;
        ovfD = (d1_in[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != d1_in[WIDTH-1]);
      end
      OP_ADDU: resD = sum;
      OP_SUB: begin
        resD  = diff;
        ovfD  = (d1_in[WIDTH-1] != opB[WIDTH-1]) && (diff[WIDTH-1] != d1_in[WIDTH-1]);
        zeroD = (diff == '0);
      end
      OP_SUBU: resD = diff;
      OP_AND:  resD = d1_in & opB;
      OP_OR:   resD = d1_in | opB;
      OP_NOR:  resD = ~(d1_in | opB);
      OP_PASS: resD = opB;
      OP_SLL:  resD = d2_in << shamt;
      OP_SRL:  resD = d2_in >> shamt;
      OP_SRA:  resD = $signed(d2_in) >>> shamt;
      OP_SLT: begin
        zeroD = $signed(d1_in) < $signed(opB);
        resD  = WIDTH'(zeroD);
      end
      OP_SLTU: begin
        zeroD = d1_in < opB;
        resD  = WIDTH'(zeroD);
      end
      OP_BEQ: begin
        zeroD = (d1_in == d2_in);
        resD  = WIDTH'(zeroD);
      end
      OP_BNE: begin
        zeroD = (d1_in != d2_in);
        resD  = WIDTH'(zeroD);
      end
      OP_BGTZ: begin
        zeroD = !d1_in[WIDTH-1] && (d1_in != '0);
        resD  = WIDTH'(zeroD);
      end
      OP_BGEZ: begin
        zeroD = !d1_in[WIDTH-1];
        resD  = WIDTH'(zeroD);
      end
      OP_LUI:  resD = imm_in << (WIDTH / 2);
      OP_MFHI: resD = hi_q;
      OP_MFLO: resD = lo_q;
      default: ;
    endcase
  end

  // Sign correction of the finished iteration; divide-by-zero forces LO to ones.
  always_comb begin
    prodFix = negRes_q ? -p_q : p_q;
    quoFix  = divZero_q ? '1 : (negRes_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0]);
    remFix  = negRem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    if (divOp_q) begin
      fixHi = remFix;
      fixLo = quoFix;
    end else begin
      fixHi = prodFix[2*WIDTH-1:WIDTH];
      fixLo = prodFix[WIDTH-1:0];
    end
  end

  // Next-state logic for the handshake FSM, iteration datapath and HI/LO.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    a_d       = a_q;
    p_d       = p_q;
    divOp_d   = divOp_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dout_d    = dout_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    ovalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (isMul || isDiv) begin
            state_d   = isDiv ? DIV : MUL;
            count_d   = '0;
            a_d       = isDiv ? magB : magA;
            p_d       = {{WIDTH{1'b0}}, (isDiv ? magA : magB)};
            divOp_d   = isDiv;
            negRes_d  = negA ^ negB;
            negRem_d  = negA;
            divZero_d = (d2_in == '0);
          end else begin
            dout_d   = resD;
            zero_d   = zeroD;
            ovf_d    = ovfD;
            ovalid_d = 1'b1;
            if (aluctrl == OP_MTHI) hi_d = d1_in;
            if (aluctrl == OP_MTLO) lo_d = d1_in;
          end
        end
      end
      MUL: begin
        p_d     = {mulSum, p_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = FIX;
      end
      DIV: begin
        p_d     = {(remFits ? remNew : remTmp[WIDTH-1:0]), p_q[WIDTH-2:0], remFits};
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d  = IDLE;
        hi_d     = fixHi;
        lo_d     = fixLo;
        dout_d   = fixLo;
        zero_d   = 1'b0;
        ovf_d    = 1'b0;
        ovalid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply/divide in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      a_q       <= '0;
      p_q       <= '0;
      divOp_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dout_q    <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ovalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      a_q       <= a_d;
      p_q       <= p_d;
      divOp_q   <= divOp_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dout_q    <= dout_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      ovalid_q  <= ovalid_d;
    end
  end

endmodule

// File: tb/tb_exec_unit_md.sv
// tb_exec_unit_md: directed checks of exec_unit_md at WIDTH=32 and WIDTH=16.
module tb_exec_unit_md;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 32-bit instance signals
  logic        inValid = 1'b0, iType = 1'b0;
  logic [4:0]  aluctrl = 5'b0;
  logic [31:0] d1 = '0, d2 = '0, imm = '0;
  logic        inReady, outValid, zeroF, ovfF;
  logic [31:0] d1Out, hiOut, loOut;

  // 16-bit instance signals
  logic        inValid16 = 1'b0, iType16 = 1'b0;
  logic [4:0]  aluctrl16 = 5'b0;
  logic [15:0] d1w16 = '0, d2w16 = '0, immW16 = '0;
  logic        inReady16, outValid16, zero16, ovf16;
  logic [15:0] d1Out16, hiOut16, loOut16;

  int assertCount = 0;
  int failCount = 0;

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  exec_unit_md #(.WIDTH(32), .DIV_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .aluctrl(aluctrl), .i_type(iType), .d1_in(d1), .d2_in(d2), .imm_in(imm),
    .out_valid(outValid), .d1_out(d1Out), .zero(zeroF), .ovf(ovfF),
    .hi_out(hiOut), .lo_out(loOut)
  );

  exec_unit_md #(.WIDTH(16), .DIV_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(inValid16), .in_ready(inReady16),
    .aluctrl(aluctrl16), .i_type(iType16), .d1_in(d1w16), .d2_in(d2w16), .imm_in(immW16),
    .out_valid(outValid16), .d1_out(d1Out16), .zero(zero16), .ovf(ovf16),
    .hi_out(hiOut16), .lo_out(loOut16)
  );

  // Present one op for exactly one edge; returns 1 time unit after that edge.
  task automatic doOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic it);
    aluctrl = op; d1 = a; d2 = b; imm = im; iType = it; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic doOp16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    aluctrl16 = op; d1w16 = a; d2w16 = b; immW16 = '0; iType16 = 1'b0; inValid16 = 1'b1;
    @(posedge clk); #1;
    inValid16 = 1'b0;
  endtask

  // Wait (bounded) for a multi-cycle completion; counts cycles and busy cycles.
  task automatic waitResult(output int cycles, output int busy);
    cycles = 0;
    busy = inReady ? 0 : 1;
    while (!outValid && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (!inReady) busy++;
    end
    inValid = 1'b0;
  endtask

  task automatic waitResult16(output int cycles);
    cycles = 0;
    while (!outValid16 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // Reset held during a multiply must abort it and clear all state.
  task automatic test_reset();
    int pulses;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    doOp(5'b11110, 32'h0000_1234, '0, '0, 1'b0);
    assertCount++; if (hiOut !== 32'h0000_1234) begin failCount++; $display("[TB] FAIL mthi_before_reset: got %h want %h", hiOut, 32'h0000_1234); end
    doOp(5'b00010, 32'd1, 32'd1, '0, 1'b0);
    assertCount++; if (d1Out !== 32'd2) begin failCount++; $display("[TB] FAIL add_before_reset: got %h want %h", d1Out, 32'd2); end
    doOp(5'b11000, 32'd3, 32'd5, '0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    assertCount++; if (hiOut !== 32'h0) begin failCount++; $display("[TB] FAIL reset_hi: got %h want 0", hiOut); end
    assertCount++; if (loOut !== 32'h0) begin failCount++; $display("[TB] FAIL reset_lo: got %h want 0", loOut); end
    assertCount++; if (d1Out !== 32'h0) begin failCount++; $display("[TB] FAIL reset_d1out: got %h want 0", d1Out); end
    assertCount++; if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_outvalid: got %b want 0", outValid); end
    assertCount++; if (inReady !== 1'b1) begin failCount++; $display("[TB] FAIL reset_inready: got %b want 1", inReady); end
    assertCount++; if ({zeroF, ovfF} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_flags: got %b want 00", {zeroF, ovfF}); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (outValid) pulses++;
    end
    assertCount++; if (pulses !== 0) begin failCount++; $display("[TB] FAIL reset_stale_pulse: got %0d pulses want 0", pulses); end
    assertCount++; if (loOut !== 32'h0) begin failCount++; $display("[TB] FAIL reset_lo_after: got %h want 0", loOut); end
  endtask

  // Add/subtract, overflow and zero flag.
  task automatic test_addsub();
    doOp(5'b00010, 32'h7FFF_FFFF, 32'h0000_0001, '0, 1'b0);
    assertCount++; if (outValid !== 1'b1) begin failCount++; $display("[TB] FAIL add_valid: got %b want 1", outValid); end
    assertCount++; if (d1Out !== 32'h8000_0000) begin failCount++; $display("[TB] FAIL add_result: got %h want %h", d1Out, 32'h8000_0000); end
    assertCount++; if (ovfF !== 1'b1) begin failCount++; $display("[TB] FAIL add_ovf: got %b want 1", ovfF); end
    @(posedge clk); #1;
    assertCount++; if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL add_pulse_width: got %b want 0", outValid); end
    assertCount++; if (d1Out !== 32'h8000_0000) begin failCount++; $display("[TB] FAIL add_hold: got %h want %h", d1Out, 32'h8000_0000); end
    doOp(5'b00011, 32'h7FFF_FFFF, 32'h0000_0001, '0, 1'b0);
    assertCount++; if ({d1Out, ovfF} !== {32'h8000_0000, 1'b0}) begin failCount++; $display("[TB] FAIL addu_result_ovf: got %h/%b want 80000000/0", d1Out, ovfF); end
    doOp(5'b00110, 32'd5, 32'd5, '0, 1'b0);
    assertCount++; if ({d1Out, zeroF, ovfF} !== {32'h0, 1'b1, 1'b0}) begin failCount++; $display("[TB] FAIL sub_zero: got %h/%b/%b want 0/1/0", d1Out, zeroF, ovfF); end
    doOp(5'b00110, 32'h8000_0000, 32'h0, 32'h1, 1'b1);
    assertCount++; if ({d1Out, zeroF, ovfF} !== {32'h7FFF_FFFF, 1'b0, 1'b1}) begin failCount++; $display("[TB] FAIL sub_imm_ovf: got %h/%b/%b want 7fffffff/0/1", d1Out, zeroF, ovfF); end
  endtask

  // Multiply latency, busy stall, ignored input while busy, HI/LO readback.
  task automatic test_mult();
    int n, b;
    doOp(5'b11000, 32'h0000_0007, 32'hFFFF_FFFD, '0, 1'b0);
    aluctrl = 5'b00010; d1 = 32'h1; d2 = 32'h1; inValid = 1'b1;
    waitResult(n, b);
    assertCount++; if (n !== 33) begin failCount++; $display("[TB] FAIL mult_latency: got %0d want 33", n); end
    assertCount++; if (b !== 33) begin failCount++; $display("[TB] FAIL mult_busy: got %0d want 33", b); end
    assertCount++; if ({hiOut, loOut} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin failCount++; $display("[TB] FAIL mult_hilo: got %h_%h want ffffffff_ffffffeb", hiOut, loOut); end
    assertCount++; if (d1Out !== 32'hFFFF_FFEB) begin failCount++; $display("[TB] FAIL mult_d1out: got %h want ffffffeb", d1Out); end
    @(posedge clk); #1;
    assertCount++; if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL busy_add_ignored: got %b want 0", outValid); end
    doOp(5'b11100, '0, '0, '0, 1'b0);
    assertCount++; if (d1Out !== 32'hFFFF_FFFF) begin failCount++; $display("[TB] FAIL mfhi: got %h want ffffffff", d1Out); end
    doOp(5'b11001, 32'h0000_0007, 32'hFFFF_FFFD, '0, 1'b0);
    waitResult(n, b);
    assertCount++; if ({hiOut, loOut} !== {32'h0000_0006, 32'hFFFF_FFEB}) begin failCount++; $display("[TB] FAIL multu_hilo: got %h_%h want 00000006_ffffffeb", hiOut, loOut); end
    doOp(5'b11101, '0, '0, '0, 1'b0);
    assertCount++; if ({outValid, d1Out} !== {1'b1, 32'hFFFF_FFEB}) begin failCount++; $display("[TB] FAIL mflo_on_done: got %b/%h want 1/ffffffeb", outValid, d1Out); end
  endtask

  // Signed/unsigned divide including divide-by-zero and MIN/-1.
  task automatic test_div();
    int n, b;
    doOp(5'b11010, 32'hFFFF_FFF9, 32'h0000_0002, '0, 1'b0);
    waitResult(n, b);
    assertCount++; if ({hiOut, loOut} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin failCount++; $display("[TB] FAIL div_neg: got %h_%h want ffffffff_fffffffd", hiOut, loOut); end
    doOp(5'b11011, 32'h0000_0009, 32'h0, '0, 1'b0);
    waitResult(n, b);
    assertCount++; if (n !== 33) begin failCount++; $display("[TB] FAIL divu_zero_latency: got %0d want 33", n); end
    assertCount++; if ({hiOut, loOut} !== {32'h0000_0009, 32'hFFFF_FFFF}) begin failCount++; $display("[TB] FAIL divu_zero: got %h_%h want 00000009_ffffffff", hiOut, loOut); end
    doOp(5'b11010, 32'h8000_0000, 32'hFFFF_FFFF, '0, 1'b0);
    waitResult(n, b);
    assertCount++; if ({hiOut, loOut, ovfF} !== {32'h0, 32'h8000_0000, 1'b0}) begin failCount++; $display("[TB] FAIL div_min_m1: got %h_%h/%b want 00000000_80000000/0", hiOut, loOut, ovfF); end
    doOp(5'b11010, 32'hFFFF_FFF9, 32'h0, '0, 1'b0);
    waitResult(n, b);
    assertCount++; if ({hiOut, loOut} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin failCount++; $display("[TB] FAIL div_zero_signed: got %h_%h want fffffff9_ffffffff", hiOut, loOut); end
  endtask

  // Shifts, compares, LUI and an illegal code.
  task automatic test_shift_cmp();
    doOp(5'b01111, '0, 32'h8000_0000, 32'd4, 1'b0);
    assertCount++; if (d1Out !== 32'hF800_0000) begin failCount++; $display("[TB] FAIL sra: got %h want f8000000", d1Out); end
    doOp(5'b01110, '0, 32'h8000_0000, 32'd4, 1'b0);
    assertCount++; if (d1Out !== 32'h0800_0000) begin failCount++; $display("[TB] FAIL srl: got %h want 08000000", d1Out); end
    doOp(5'b01101, '0, 32'h0000_0001, 32'd31, 1'b0);
    assertCount++; if (d1Out !== 32'h8000_0000) begin failCount++; $display("[TB] FAIL sll_max: got %h want 80000000", d1Out); end
    doOp(5'b10100, 32'hFFFF_FFFF, '0, '0, 1'b0);
    assertCount++; if ({d1Out, zeroF} !== {32'h0, 1'b0}) begin failCount++; $display("[TB] FAIL bgez_neg: got %h/%b want 0/0", d1Out, zeroF); end
    doOp(5'b10011, 32'h0000_0001, '0, '0, 1'b0);
    assertCount++; if ({d1Out, zeroF} !== {32'h1, 1'b1}) begin failCount++; $display("[TB] FAIL bgtz_pos: got %h/%b want 1/1", d1Out, zeroF); end
    doOp(5'b10001, 32'hFFFF_FFFF, 32'h1, '0, 1'b0);
    assertCount++; if ({d1Out, zeroF} !== {32'h0, 1'b0}) begin failCount++; $display("[TB] FAIL sltu: got %h/%b want 0/0", d1Out, zeroF); end
    doOp(5'b10000, 32'hFFFF_FFFF, 32'h1, '0, 1'b0);
    assertCount++; if ({d1Out, zeroF} !== {32'h1, 1'b1}) begin failCount++; $display("[TB] FAIL slt: got %h/%b want 1/1", d1Out, zeroF); end
    doOp(5'b10010, 32'd5, 32'd5, 32'd9, 1'b1);
    assertCount++; if (zeroF !== 1'b1) begin failCount++; $display("[TB] FAIL beq: got %b want 1", zeroF); end
    doOp(5'b10101, '0, '0, 32'h0000_1234, 1'b1);
    assertCount++; if (d1Out !== 32'h1234_0000) begin failCount++; $display("[TB] FAIL lui: got %h want 12340000", d1Out); end
    doOp(5'b01000, 32'h5, 32'h5, '0, 1'b0);
    assertCount++; if ({outValid, d1Out, zeroF} !== {1'b1, 32'h0, 1'b0}) begin failCount++; $display("[TB] FAIL illegal: got %b/%h/%b want 1/0/0", outValid, d1Out, zeroF); end
  endtask

  // Four single-cycle ops on consecutive edges, LO forwarded through MTLO/MFLO.
  task automatic test_back_to_back();
    doOp(5'b00000, 32'h0000_F0F0, 32'h0000_FF00, '0, 1'b0);
    assertCount++; if ({outValid, d1Out} !== {1'b1, 32'h0000_F000}) begin failCount++; $display("[TB] FAIL b2b_and: got %b/%h want 1/0000f000", outValid, d1Out); end
    doOp(5'b00001, 32'h0000_F0F0, 32'h0000_FF00, '0, 1'b0);
    assertCount++; if ({outValid, d1Out} !== {1'b1, 32'h0000_FFF0}) begin failCount++; $display("[TB] FAIL b2b_or: got %b/%h want 1/0000fff0", outValid, d1Out); end
    doOp(5'b11111, 32'h0000_ABCD, '0, '0, 1'b0);
    assertCount++; if ({outValid, d1Out} !== {1'b1, 32'h0}) begin failCount++; $display("[TB] FAIL b2b_mtlo: got %b/%h want 1/0", outValid, d1Out); end
    doOp(5'b11101, '0, '0, '0, 1'b0);
    assertCount++; if ({outValid, d1Out} !== {1'b1, 32'h0000_ABCD}) begin failCount++; $display("[TB] FAIL b2b_mflo: got %b/%h want 1/0000abcd", outValid, d1Out); end
  endtask

  // Narrow instance: multiply latency WIDTH+1 and the same back-to-back stream.
  task automatic test_width16();
    int n;
    doOp16(5'b11000, 16'h0007, 16'hFFFD);
    assertCount++; if (inReady16 !== 1'b0) begin failCount++; $display("[TB] FAIL w16_busy: got %b want 0", inReady16); end
    waitResult16(n);
    assertCount++; if (n !== 17) begin failCount++; $display("[TB] FAIL w16_mult_latency: got %0d want 17", n); end
    assertCount++; if ({hiOut16, loOut16} !== {16'hFFFF, 16'hFFEB}) begin failCount++; $display("[TB] FAIL w16_mult_hilo: got %h_%h want ffff_ffeb", hiOut16, loOut16); end
    doOp16(5'b00000, 16'hF0F0, 16'hFF00);
    assertCount++; if ({outValid16, d1Out16} !== {1'b1, 16'hF000}) begin failCount++; $display("[TB] FAIL w16_and: got %b/%h want 1/f000", outValid16, d1Out16); end
    doOp16(5'b00001, 16'hF0F0, 16'hFF00);
    assertCount++; if ({outValid16, d1Out16} !== {1'b1, 16'hFFF0}) begin failCount++; $display("[TB] FAIL w16_or: got %b/%h want 1/fff0", outValid16, d1Out16); end
    doOp16(5'b11111, 16'hABCD, 16'h0);
    assertCount++; if ({outValid16, d1Out16} !== {1'b1, 16'h0}) begin failCount++; $display("[TB] FAIL w16_mtlo: got %b/%h want 1/0", outValid16, d1Out16); end
    doOp16(5'b11101, 16'h0, 16'h0);
    assertCount++; if ({outValid16, d1Out16} !== {1'b1, 16'hABCD}) begin failCount++; $display("[TB] FAIL w16_mflo: got %b/%h want 1/abcd", outValid16, d1Out16); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] starting exec_unit_md bench");
    test_reset();
    test_addsub();
    test_mult();
    test_div();
    test_shift_cmp();
    test_back_to_back();
    test_width16();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
